// File: rtl/chooser_pkg.sv
// Shared definitions for the round-robin/fixed channel chooser.
// Holds the mode encodings and the select-width helper.
package chooser_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // A one-channel-wide index still needs one bit, so never return zero.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chooser_rr_reg_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr, cyclic.
// Pure logic, no state.
module rr_pick
    import chooser_pkg::*;
#(
    parameter  int NCH  = 4,
    localparam int SELW = clog2_min1(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic            gnt_vld,
    output logic [SELW-1:0] gnt_idx
);

    logic [2*NCH-1:0] dbl;
    logic [NCH-1:0]   rot;
    int               start;
    int               idx;

    // Rotate the doubled request vector so bit 0 is the channel at ptr.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        start   = (32'(ptr) < NCH) ? int'(ptr) : 0;
        dbl     = {req, req} >> start;
        rot     = dbl[NCH-1:0];
        for (int i = 0; i < NCH; i++) begin
            if (!gnt_vld && rot[i]) begin
                gnt_vld = 1'b1;
                idx     = start + i;
                if (idx >= NCH) begin
                    idx = idx - NCH;
                end
                gnt_idx = SELW'(idx);
            end
        end
    end

endmodule

// File: rtl/chooser_rr_reg.sv
// N-channel, W-bit selector with a registered output and valid/ready on every port.
// FIXED mode follows sel; RR mode rotates a pointer among valid channels.
module chooser_rr_reg
    import chooser_pkg::*;
#(
    parameter  int NCH  = 4,
    parameter  int W    = 2,
    localparam int SELW = clog2_min1(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [SELW-1:0]   sel,
    input  logic [NCH*W-1:0]  in_data,
    input  logic [NCH-1:0]    in_valid,
    output logic [NCH-1:0]    in_ready,
    output logic [W-1:0]      out_data,
    output logic [SELW-1:0]   out_chan,
    output logic              out_valid,
    input  logic              out_ready
);

    logic [W-1:0]    out_data_q, out_data_d;
    logic [SELW-1:0] out_chan_q, out_chan_d;
    logic            out_valid_q, out_valid_d;
    logic [SELW-1:0] ptr_q, ptr_d;

    logic            rr_vld;
    logic [SELW-1:0] rr_idx;
    logic            grant_vld;
    logic [SELW-1:0] grant_idx;
    logic            load_en;
    logic            xfer;
    logic [W-1:0]    grant_data;

    rr_pick #(.NCH(NCH)) u_pick (
        .req     (in_valid),
        .ptr     (ptr_q),
        .gnt_vld (rr_vld),
        .gnt_idx (rr_idx)
    );

    assign load_en = !out_valid_q || out_ready;

    // FIXED grants sel regardless of its valid; an out-of-range sel grants nobody.
    always_comb begin
        grant_vld  = 1'b0;
        grant_idx  = '0;
        grant_data = '0;
        in_ready   = '0;
        if (mode == MODE_FIXED) begin
            grant_vld = (32'(sel) < NCH);
            grant_idx = sel;
        end else begin
            grant_vld = rr_vld;
            grant_idx = rr_idx;
        end
        for (int i = 0; i < NCH; i++) begin
            if (SELW'(i) == grant_idx) begin
                grant_data  = in_data[i*W +: W];
                in_ready[i] = grant_vld && load_en && !rst;
            end
        end
    end

    assign xfer = |(in_valid & in_ready);

    // Pointer wraps explicitly so non-power-of-2 channel counts stay in range.
    always_comb begin
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_data_d  = grant_data;
            out_chan_d  = grant_idx;
            out_valid_d = 1'b1;
            if (mode == MODE_RR) begin
                ptr_d = (grant_idx == SELW'(NCH - 1)) ? '0 : grant_idx + 1'b1;
            end
        end else if (load_en) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_chan_q  <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;
    assign out_valid = out_valid_q;

endmodule

// File: doc/chooser_rr_reg.md
Name: chooser_rr_reg

Overview:
- Parametrised successor to the gate-level 2-to-1 selector: N-channel, W-bit selector with a registered output stage and valid/ready handshakes on every input and on the output.
- Two selection modes: fixed (external `sel`) and round-robin (internal rotating pointer among valid channels).
- Sits between lab data sources (switch or counter channels) and a display/consumer stage that may stall.

Parameters:
- NCH, 4, number of input channels (>=2).
- W, 2, data width per channel (>=1).
- SELW, $clog2(NCH), width of `sel`, `out_chan` and the internal pointer; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  1  0 = FIXED, 1 = RR.
- sel  in  SELW  channel index used in FIXED mode.
- in_data  in  NCH*W  channel i occupies bits [i*W +: W].
- in_valid  in  NCH  per-channel valid.
- in_ready  out  NCH  per-channel ready; at most one bit high.
- out_data  out  W  registered selected data.
- out_chan  out  SELW  index of the channel held in out_data.
- out_valid  out  1  output register holds data.
- out_ready  in  1  consumer accepts data.

Behaviour:
- Reset: this is the only sequential reset, synchronous and active-high on the clk edge with rst=1. It sets out_valid=0, out_data=0, out_chan=0 and the RR pointer ptr=0. in_ready is combinational, so it is all-zero while rst=1. A reset mid-transfer discards the held word.
- Load enable: load_en = !out_valid || out_ready. The output register takes new data only when load_en=1, which gives full throughput (1 word/cycle) with no bubble when draining and loading in the same cycle.
- Grant in FIXED mode:
  - grant = sel when sel < NCH.
  - If sel >= NCH (non-power-of-2 NCH), no channel is granted.
  - in_valid of the selected channel is not required for the grant; in_ready[sel] = load_en.
- Grant in RR mode:
  - Search channels ptr, ptr+1, ..., wrapping modulo NCH, for the first in_valid=1.
  - That channel is granted, and only it sees in_ready=load_en.
  - No valid channel means no grant and all in_ready=0.
- Transfer on channel g = in_valid[g] && in_ready[g].
  - Next edge: out_data <= channel g data, out_chan <= g, out_valid <= 1.
  - In RR mode also: ptr <= (g == NCH-1) ? 0 : g+1. Wrap is explicit, never by overflow, so it is correct for non-power-of-2 NCH.
- No transfer while out_ready=1 and out_valid=1: out_valid <= 0 next edge. out_data and out_chan hold their last value.
- Stall (out_valid=1, out_ready=0): out_data, out_chan and out_valid hold; all in_ready=0.
- Latency: input transfer to out_valid is 1 cycle. There is no combinational path from in_data to out_data.
- Mode switch:
  - Takes effect on the cycle mode changes; there is no pipeline state other than the output register.
  - ptr is retained across FIXED periods and is not updated by FIXED transfers.
- Simultaneous valids in RR mode: the lowest index at or after ptr (cyclic) wins. Each requesting channel is served within NCH transfers (starvation-free).
- Input/output handshake rules:
  - Inputs may drop in_valid without handshake; the block must not rely on valid stability.
  - The output obeys AXI-style stability: while out_valid=1 and out_ready=0, out_data and out_chan must not change.

Decomposition:
- Shared package chooser_pkg:
  - MODE_FIXED = 1'b0, MODE_RR = 1'b1.
  - Function clog2_min1 (returns at least 1) for SELW.
- One sub-module: rr_pick, a combinational rotating-priority picker.
  - Inputs: req[NCH], ptr[SELW].
  - Outputs: gnt_vld, gnt_idx[SELW].
  - Implemented by double-width request vector or loop; no state.
- Top level holds ptr, the output register and the handshake logic.

Test Plan:
- Reset: assert rst for 2 cycles with random inputs -> out_valid=0, out_data=0, out_chan=0, in_ready=0000. After release with in_valid=0000 in RR mode -> in_ready stays 0000.
- FIXED pass-through, NCH=4 W=2:
  - Stimulus: mode=0, sel=2, in_data ch2=2'b11, in_valid=0100, out_ready=1.
  - Required: in_ready=0100 same cycle; next cycle out_data=11, out_chan=2, out_valid=1.
  - Then change sel=1 with ch1=01 -> following cycle out_data=01, out_chan=1.
- RR fairness:
  - Stimulus: mode=1, in_valid=1111, channels hold 0,1,2,3, out_ready=1 constant.
  - Required: out_chan sequence 0,1,2,3,0,1 on consecutive cycles, out_valid continuously 1.
  - Then in_valid=1001 -> grants alternate 3,0,3,0.
- Backpressure:
  - Stimulus: RR, in_valid=0010, out_ready=0 for 3 cycles after the first load.
  - Required: out_data/out_chan stable, in_ready=0000 during the stall.
  - On out_ready=1: same-cycle in_ready=0010 and a new word next cycle, with no gap.
- Mode switch plus non-power-of-2:
  - Stimulus: NCH=3, FIXED with sel=3.
  - Required: in_ready=000, out_valid drains to 0.
  - Then RR with ptr=2, in_valid=111 -> grant 2, then ptr wraps to 0 and grant 0.
- Reset mid-stall: out_valid=1, out_ready=0, rst=1 for one cycle -> next cycle out_valid=0, ptr=0, and the first RR grant is channel 0.
